// File: rtl/sd_pkg.sv
// Shared types and constants for the LVDA serial-data path.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } sd_ser_state_t;

  localparam int SD_WORD_WIDTH = 26;
  localparam int SD_PARITY_ODD = 1;

endpackage

// File: rtl/sd_bit_counter.sv
// Counts data-bit strobes within one word; saturates at WIDTH so it never wraps.
module sd_bit_counter
  import sd_pkg::*;
#(
  parameter int WIDTH = SD_WORD_WIDTH
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CW'(WIDTH))) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count: high on the enable that brings the count to WIDTH.
  assign tc = en && (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sd_serializer.sv
// Captures the ML sample bits on request and shifts them out MSB-first,
// optionally followed by an odd-parity bit, one bit per BITSTB.
module sd_serializer
  import sd_pkg::*;
#(
  parameter int WIDTH     = SD_WORD_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic [WIDTH-1:0] ML,
  input  logic             SDREQ,
  input  logic             BITSTB,
  output logic             SDO,
  output logic             SDVAL,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVR
);

  // Handshake: SDVAL high means SDO holds the current bit; the bit is
  // consumed by the BITSTB cycle, and the next bit appears the cycle after.
  sd_ser_state_t state, state_next;

  logic [WIDTH-1:0] shreg;
  logic             par;
  logic             ovr;
  logic             accept;
  logic             shift_en;
  logic             last_bit;

  assign accept   = (state == IDLE) && SDREQ;
  assign shift_en = (state == SHIFT) && BITSTB;

  sd_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .clr     (accept),
    .en      (shift_en),
    .tc      (last_bit)
  );

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    SDO        = 1'b0;
    SDVAL      = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE: begin
        if (SDREQ) state_next = SHIFT;
      end
      SHIFT: begin
        SDO   = shreg[WIDTH-1];
        SDVAL = 1'b1;
        BUSY  = 1'b1;
        if (last_bit) state_next = PARITY_EN ? PAR : FIN;
      end
      PAR: begin
        SDO   = par;
        SDVAL = 1'b1;
        BUSY  = 1'b1;
        if (BITSTB) state_next = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        BUSY       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Parity is taken from ML at capture so later ML changes cannot leak in.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      shreg <= '0;
      par   <= 1'b0;
      ovr   <= 1'b0;
    end else if (accept) begin
      shreg <= ML;
      par   <= (^ML) ^ 1'(SD_PARITY_ODD);
      ovr   <= 1'b0;
    end else begin
      if (shift_en) shreg <= {shreg[WIDTH-2:0], 1'b0};
      if ((state != IDLE) && SDREQ) ovr <= 1'b1;
    end
  end

  assign OVR = ovr;

endmodule

// File: tb/tb_sd_serializer.sv
// Directed and randomized checks of sd_serializer against a bit-list model,
// with one instance using parity and one without.
module tb_sd_serializer;

  localparam int W = 26;

  logic         SIM_CLK;
  logic         SIM_RST;
  logic [W-1:0] ML;
  logic         BITSTB;
  logic         req1, req0;
  logic         sdo1, sdval1, busy1, done1, ovr1;
  logic         sdo0, sdval0, busy0, done0, ovr0;

  int           n_chk;
  int           n_err;
  bit           sel;
  bit           exp_ovr[2];
  logic [0:0]   exp_q[$];

  sd_serializer #(.WIDTH(W), .PARITY_EN(1'b1)) dut1 (
    .SIM_CLK (SIM_CLK), .SIM_RST (SIM_RST), .ML (ML), .SDREQ (req1), .BITSTB (BITSTB),
    .SDO (sdo1), .SDVAL (sdval1), .BUSY (busy1), .DONE (done1), .OVR (ovr1)
  );

  sd_serializer #(.WIDTH(W), .PARITY_EN(1'b0)) dut0 (
    .SIM_CLK (SIM_CLK), .SIM_RST (SIM_RST), .ML (ML), .SDREQ (req0), .BITSTB (BITSTB),
    .SDO (sdo0), .SDVAL (sdval0), .BUSY (busy0), .DONE (done0), .OVR (ovr0)
  );

  // clock / reset
  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  // scoreboard compare
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_sdo, input logic e_sdval,
                           input logic e_busy, input logic e_done, input logic e_ovr);
    if (sel) begin
      chk({tag, ".p1.sdo"}, sdo1, e_sdo);
      chk({tag, ".p1.sdval"}, sdval1, e_sdval);
      chk({tag, ".p1.busy"}, busy1, e_busy);
      chk({tag, ".p1.done"}, done1, e_done);
      chk({tag, ".p1.ovr"}, ovr1, e_ovr);
    end else begin
      chk({tag, ".p0.sdo"}, sdo0, e_sdo);
      chk({tag, ".p0.sdval"}, sdval0, e_sdval);
      chk({tag, ".p0.busy"}, busy0, e_busy);
      chk({tag, ".p0.done"}, done0, e_done);
      chk({tag, ".p0.ovr"}, ovr0, e_ovr);
    end
  endtask

  // driver
  task automatic set_req(input logic v);
    if (sel) req1 = v;
    else     req0 = v;
  endtask

  task automatic next_cycle();
    @(posedge SIM_CLK);
    #1;
  endtask

  // Sends one word to the selected DUT. stop_after >= 0 returns after that many
  // strobes (for an abort); ovr_at >= 0 raises SDREQ just after that many strobes.
  task automatic send_word(input logic [W-1:0] ml, input int gap, input bit stb_on_req,
                           input int ovr_at, input int stop_after);
    int  nbits;
    bit  req_now;
    nbits = W + (sel ? 1 : 0);
    exp_q.delete();
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(ml[i]);
    if (sel) exp_q.push_back(($countones(ml) % 2 == 0) ? 1'b1 : 1'b0);

    ML     = ml;
    BITSTB = stb_on_req;
    set_req(1'b1);
    @(negedge SIM_CLK);
    check_out("accept", 1'b0, 1'b0, 1'b0, 1'b0, exp_ovr[sel]);
    next_cycle();
    exp_ovr[sel] = 1'b0;
    set_req(1'b0);
    BITSTB = 1'b0;
    ML     = W'($urandom);

    for (int b = 0; b < nbits; b++) begin
      if (b == stop_after) return;
      for (int g = 0; g < gap; g++) begin
        BITSTB  = (g == gap - 1);
        req_now = (b == ovr_at) && (g == 0);
        if (req_now) set_req(1'b1);
        @(negedge SIM_CLK);
        check_out(b == W ? "parity_bit" : "data_bit", exp_q[0], 1'b1, 1'b1, 1'b0, exp_ovr[sel]);
        next_cycle();
        if (req_now) exp_ovr[sel] = 1'b1;
        set_req(1'b0);
        BITSTB = 1'b0;
      end
      void'(exp_q.pop_front());
    end

    @(negedge SIM_CLK);
    check_out("fin", 1'b0, 1'b0, 1'b1, 1'b1, exp_ovr[sel]);
    next_cycle();
    @(negedge SIM_CLK);
    check_out("post_fin", 1'b0, 1'b0, 1'b0, 1'b0, exp_ovr[sel]);
    next_cycle();
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    sel     = 1'b1;
    exp_ovr = '{1'b0, 1'b0};
    SIM_RST = 1'b0;
    req1    = 1'b1;
    req0    = 1'b1;
    BITSTB  = 1'b1;
    ML      = W'($urandom);
    next_cycle();

    // reset held with request and strobe active
    for (int c = 0; c < 3; c++) begin
      sel = 1'b1;
      @(negedge SIM_CLK);
      check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sel = 1'b0;
      check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    req1    = 1'b0;
    req0    = 1'b0;
    BITSTB  = 1'b0;
    SIM_RST = 1'b1;
    @(negedge SIM_CLK);
    sel = 1'b1;
    check_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // directed words with parity
    sel = 1'b1;
    send_word(26'h2AAAAAA, 4, 1'b0, -1, -1);
    send_word(26'h0000010, 2, 1'b0, -1, -1);
    send_word(26'h0000000, 1, 1'b0, -1, -1);
    send_word(26'h3FFFFFF, 1, 1'b0, -1, -1);

    // overrun after 5 strobes, then cleared by the next accepted request
    send_word(W'($urandom), 3, 1'b0, 5, -1);
    send_word(W'($urandom), 2, 1'b0, -1, -1);

    // reset after 10 strobes
    send_word(W'($urandom), 2, 1'b0, -1, 10);
    SIM_RST = 1'b0;
    next_cycle();
    SIM_RST = 1'b1;
    exp_ovr = '{1'b0, 1'b0};
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge SIM_CLK);
      check_out("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    send_word(W'($urandom), 2, 1'b0, -1, -1);

    // strobe coincident with request, both parity settings
    send_word(W'($urandom), 2, 1'b1, -1, -1);
    sel = 1'b0;
    send_word(W'($urandom), 2, 1'b1, -1, -1);
    send_word(26'h2AAAAAA, 3, 1'b0, 4, -1);

    // randomized words
    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(1, 0));
      send_word(W'($urandom), $urandom_range(4, 1), 1'($urandom_range(1, 0)),
                ($urandom_range(3, 0) == 0) ? $urandom_range(W - 1, 0) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_serializer.md
Name: sd_serializer

Overview:
- Downstream of the sd_sampler stages in the LVDA.
- Captures the parallel ML sample bits (ML1..MLn) on a transfer request and shifts them out MSB-first as a serial data word toward the LVDC, with an optional odd-parity bit appended.
- Bit timing comes from an external bit-rate strobe.
- Reports busy, completion and request overrun.

Parameters:
- WIDTH, 26, number of ML sample bits captured per word.
- PARITY_EN, 1, 1 = append an odd-parity bit after the data bits; 0 = no parity bit.

Ports:
- SIM_CLK  in  1  single system clock; all state changes on its rising edge.
- SIM_RST  in  1  reset, synchronous and active-low.
- ML  in  WIDTH  parallel sampler outputs; ML[i] carries ML(i+1), so ML[4] = ML5 and ML[5] = ML6.
- SDREQ  in  1  transfer request; level sampled each cycle.
- BITSTB  in  1  one-cycle bit-rate strobe; advances the serial output by one bit.
- SDO  out  1  serial data bit.
- SDVAL  out  1  high while SDO carries a valid bit.
- BUSY  out  1  high from request acceptance until DONE is issued.
- DONE  out  1  one-cycle pulse after the final bit.
- OVR  out  1  sticky overrun flag.

Behaviour:
- Reset (SIM_RST=0 at a clock edge):
  - State = IDLE; shift register, bit count and parity cleared.
  - SDO=0, SDVAL=0, BUSY=0, DONE=0, OVR=0.
  - Applies mid-transfer too: the partial word is discarded, no DONE is issued.
- States: IDLE, SHIFT, PAR, FIN.
- IDLE:
  - Outputs SDO=0, SDVAL=0, BUSY=0.
  - If SDREQ=1 at cycle n: capture ML into the shift register, compute par = ~^ML, clear count, clear OVR, go to SHIFT.
  - SDVAL=1 and BUSY=1 from cycle n+1; SDO = ML[WIDTH-1] from cycle n+1.
  - A BITSTB in the acceptance cycle is ignored.
- SHIFT:
  - SDO = shift register MSB; SDVAL=1.
  - On each BITSTB: shift left one bit (zero fill), count+1.
  - On the BITSTB that makes count = WIDTH: go to PAR if PARITY_EN=1, else go to FIN.
- PAR:
  - SDO = par; SDVAL=1.
  - On BITSTB go to FIN.
- FIN:
  - Lasts exactly one cycle: DONE=1, SDVAL=0, SDO=0, BUSY=1.
  - Then IDLE.
  - A new request can be accepted in the cycle after FIN at the earliest.
- Word length:
  - WIDTH+PARITY_EN bits; each bit valid from the strobe that ends the previous bit up to and including its own strobe cycle.
- Parity:
  - Odd; total ones across data bits plus the parity bit is odd.
  - Computed from the captured value, not the live ML.
- Overrun:
  - SDREQ=1 in SHIFT, PAR or FIN sets OVR=1.
  - The request is otherwise ignored; the transfer in progress is unaffected.
  - OVR holds until reset or the next accepted request.
- ML changes after capture do not affect the word in flight.
- No BITSTB: the block holds the current bit indefinitely; there is no timeout.
- Counter width: clog2(WIDTH+1); no wrap within a word.

Decomposition:
- Shared package sd_pkg:
  - State enum sd_ser_state_t {IDLE, SHIFT, PAR, FIN}.
  - Constant SD_WORD_WIDTH = 26.
  - Constant SD_PARITY_ODD = 1.
- One sub-module: sd_bit_counter.
  - Synchronous clear and enable.
  - Terminal-count output at WIDTH.
  - Same SIM_CLK/SIM_RST.
- Shift register, parity and FSM stay in sd_serializer.

Test Plan:
- Reset: hold SIM_RST=0 for 3 cycles with SDREQ=1 and BITSTB=1 -> SDO, SDVAL, BUSY, DONE and OVR all 0 throughout; no capture.
- Alternating word: ML=26'h2AAAAAA (13 ones), SDREQ pulse, then BITSTB every 4 cycles -> SDO emits 1,0,1,0,... for 26 bits, then parity 0; DONE pulses once in the cycle after the 27th strobe; BUSY falls the following cycle.
- Single-bit and all-zero words:
  - ML=26'h0000010 (ML5 only) -> SDO=1 only on the 22nd emitted bit; parity 0.
  - ML=0 -> all 26 data bits 0; parity bit 1.
- Overrun: assert SDREQ during SHIFT after 5 strobes -> OVR=1 next cycle; the word completes unchanged with DONE; the next accepted SDREQ clears OVR.
- Mid-transfer reset: SIM_RST=0 after 10 strobes -> all outputs 0 next cycle and no DONE; the next request restarts from ML[25] with the newly captured value.
- Strobe coincidence and PARITY_EN=0: BITSTB in the same cycle as SDREQ is ignored (the first bit still equals ML[25]); with PARITY_EN=0, DONE follows the 26th counted strobe.
